// File: rtl/spi_master_ctrl.sv
// SPI master: sends an 11-bit command frame, optionally turns the bus around and
// shifts in one read byte, then holds SS_n high for a minimum gap before idling.
module spi_master_ctrl #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_TURN, S_RECV, S_GAP} state_e;

  // Each phase loads the counter with its length minus one and leaves at zero.
  localparam logic [3:0] FRAME_LAST = 4'd10;
  localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ss_n_q, ss_n_d;
  logic [10:0] frame_q;
  logic        rd_cmd_q;
  logic [7:0]  rx_q;
  logic [7:0]  rd_data_q;
  logic        rd_valid_q;
  logic        accept;
  logic        recv_last;

  assign accept    = (state_q == S_IDLE) && start;
  assign recv_last = (state_q == S_RECV) && (cnt_q == 4'd0);

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the pre-edge values regardless of process or statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ss_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ss_n_q  <= ss_n_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned (no latch).
    state_d = state_q;
    cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FRAME;
          cnt_d   = FRAME_LAST;
        end
      end
      S_FRAME: begin
        if (cnt_q == 4'd0) begin
          state_d = rd_cmd_q ? S_TURN : S_GAP;
          cnt_d   = rd_cmd_q ? TURN_LAST : GAP_LAST;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECV;
          cnt_d   = RECV_LAST;
        end
      end
      S_RECV: begin
        if (cnt_q == 4'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // SS_n is registered from the next state so it never glitches on decode.
    ss_n_d = !(state_d inside {S_FRAME, S_TURN, S_RECV});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      rd_cmd_q   <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        frame_q  <= {cmd[1], cmd, wdata};
        rd_cmd_q <= &cmd;
      end else if (state_q == S_FRAME) begin
        frame_q <= {frame_q[9:0], 1'b0};
      end
      if (state_q == S_RECV) rx_q <= {rx_q[6:0], MISO};
      if (recv_last) rd_data_q <= {rx_q[6:0], MISO};
      rd_valid_q <= recv_last;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_GAP) && (cnt_q == 4'd0);
    MOSI = (state_q == S_FRAME) ? frame_q[10] : 1'b0;
  end

  assign SS_n     = ss_n_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: SPI slave+RAM model on the default
// instance, a scoreboard of the RAM contents, and a latency sweep over parameters.
module tb_spi_master_ctrl;

  localparam int DUT_T = 2;
  localparam int DUT_G = 1;
  localparam int SW_T [4] = '{1, 1, 3, 3};
  localparam int SW_G [4] = '{1, 4, 1, 4};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy, done, rd_valid, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO;

  logic       sw_start;
  logic [1:0] sw_cmd;
  logic [7:0] sw_wdata;
  logic       sw_miso;
  logic [3:0] sw_busy, sw_done, sw_rd_valid, sw_ss_n, sw_mosi;
  logic [7:0] sw_rd_data [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.TURN_CYCLES(DUT_T), .GAP_CYCLES(DUT_G)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .wdata(wdata),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    spi_master_ctrl #(.TURN_CYCLES(SW_T[g]), .GAP_CYCLES(SW_G[g])) u_sw (
      .clk(clk), .rst(rst), .start(sw_start), .cmd(sw_cmd), .wdata(sw_wdata),
      .busy(sw_busy[g]), .done(sw_done[g]), .rd_data(sw_rd_data[g]),
      .rd_valid(sw_rd_valid[g]), .SS_n(sw_ss_n[g]), .MOSI(sw_mosi[g]), .MISO(sw_miso)
    );
  end

  // SPI slave with a 256-byte RAM: 00 sets write address, 01 writes, 10 sets
  // read address, 11 returns the addressed byte after the turnaround.
  logic [7:0]  slv_mem [256];
  logic [9:0]  slv_sh;
  logic [10:0] slv_word;
  logic [7:0]  slv_waddr, slv_raddr, slv_rbyte;
  logic        slv_rd;
  int          slv_pos;

  assign slv_word = {slv_sh, MOSI};

  always @(posedge clk) begin
    if (SS_n !== 1'b0) begin
      slv_pos <= 0;
      slv_rd  <= 1'b0;
    end else begin
      slv_pos <= slv_pos + 1;
      if (slv_pos < 11) slv_sh <= slv_word[9:0];
      if (slv_pos == 10) begin
        case (slv_word[9:8])
          2'b00: slv_waddr <= slv_word[7:0];
          2'b01: slv_mem[slv_waddr] <= slv_word[7:0];
          2'b10: slv_raddr <= slv_word[7:0];
          default: begin
            slv_rbyte <= slv_mem[slv_raddr];
            slv_rd    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Outside its data window the slave drives noise so mistimed sampling shows up.
  always @(negedge clk) begin
    if (SS_n === 1'b0 && slv_rd && slv_pos >= 11 + DUT_T && slv_pos <= 18 + DUT_T)
      MISO = slv_rbyte[7 - (slv_pos - 11 - DUT_T)];
    else
      MISO = 1'($urandom);
  end

  // Scoreboard: what the slave RAM should hold given the accepted commands.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_waddr, ref_raddr;

  function automatic int exp_latency(input logic [1:0] c, input int t, input int g);
    return (c == 2'b11) ? 19 + t + g : 11 + g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // Called at a negedge with busy low; returns at the negedge where done is seen.
  task automatic do_txn(input string tag, input logic [1:0] c, input logic [7:0] d, input bit hold);
    logic [10:0] exp_frame, obs_frame;
    logic [7:0]  exp_rd;
    int lat, ss_low, busy_low, rv_cnt;
    exp_frame = {c[1], c, d};
    exp_rd    = ref_mem[ref_raddr];
    obs_frame = '0;
    ss_low = 0; busy_low = 0; rv_cnt = 0; lat = 0;
    start = 1'b1; cmd = c; wdata = d;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) start = 1'b0;
      cmd   = 2'($urandom);
      wdata = 8'($urandom);
      if (lat <= 11) obs_frame = {obs_frame[9:0], MOSI};
      if (SS_n === 1'b0) ss_low++;
      if (busy !== 1'b1) busy_low++;
      if (rd_valid === 1'b1) rv_cnt++;
    end while (done !== 1'b1 && lat < 80);
    check({tag, "_frame"}, 32'(obs_frame), 32'(exp_frame));
    check({tag, "_latency"}, lat, exp_latency(c, DUT_T, DUT_G));
    check({tag, "_ss_low_cycles"}, ss_low, (c == 2'b11) ? 19 + DUT_T : 11);
    check({tag, "_busy_drop"}, busy_low, 0);
    check({tag, "_ss_n_at_done"}, {31'd0, SS_n}, 32'd1);
    check({tag, "_rd_valid_at_done"}, {31'd0, rd_valid}, {31'd0, (c == 2'b11)});
    check({tag, "_rd_valid_pulses"}, rv_cnt, (c == 2'b11) ? 1 : 0);
    if (c == 2'b11) check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_rd));
    case (c)
      2'b00: ref_waddr = d;
      2'b01: ref_mem[ref_waddr] = d;
      2'b10: ref_raddr = d;
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sw_lat [4];
    int sw_gap [4];
    int cnt;
    logic [1:0] sc;
    logic [7:0] hd;

    rst = 1'b1; start = 1'b0; cmd = '0; wdata = '0;
    sw_start = 1'b0; sw_cmd = '0; sw_wdata = '0; sw_miso = 1'b0;
    slv_rd = 1'b0; slv_waddr = '0; slv_raddr = '0; slv_sh = '0; slv_rbyte = '0;
    ref_waddr = '0; ref_raddr = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 8'h3C;
    slv_mem[0] = 8'h3C;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ss_n", {31'd0, SS_n}, 32'd1);
    check("reset_mosi", {31'd0, MOSI}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'h00);

    // Write-address A5, then a read with no prior read-address command.
    do_txn("wr_addr_a5", 2'b00, 8'hA5, 1'b0);
    wait_idle();
    do_txn("rd_data_3c", 2'b11, 8'h00, 1'b0);
    wait_idle();

    // start held high across a write-data frame: one frame, next accepted after done.
    hd = 8'($urandom);
    do_txn("hold_wr", 2'b01, hd, 1'b1);
    @(negedge clk);
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    check("hold_gap_ss_n", {31'd0, SS_n}, 32'd1);
    do_txn("hold_next", 2'b10, 8'hA5, 1'b0);
    wait_idle();
    do_txn("hold_readback", 2'b11, 8'h00, 1'b0);
    wait_idle();

    do_txn("ram_rd_addr", 2'b10, 8'h07, 1'b0);
    wait_idle();
    do_txn("ram_wr_addr", 2'b00, 8'h07, 1'b0);
    wait_idle();
    do_txn("ram_wr_data", 2'b01, 8'h5A, 1'b0);
    wait_idle();
    do_txn("ram_rd_5a", 2'b11, 8'h00, 1'b0);
    wait_idle();

    // Reset while FRAME bit 5 is on MOSI, with start asserted during reset.
    start = 1'b1; cmd = 2'b01; wdata = 8'($urandom);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        cmd = 2'($urandom);
        wdata = 8'($urandom);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss_n", {31'd0, SS_n}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0; start = 1'b0;
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("abort_no_activity", cnt, 0);
    do_txn("post_abort_rd", 2'b11, 8'h00, 1'b0);
    wait_idle();

    for (int n = 0; n < 24; n++) begin
      do_txn($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Latency and gap length across TURN/GAP parameter combinations.
    for (int c = 0; c < 2; c++) begin
      sc = (c == 0) ? 2'b00 : 2'b11;
      for (int g = 0; g < 4; g++) begin
        sw_lat[g] = 0;
        sw_gap[g] = 0;
      end
      sw_start = 1'b1; sw_cmd = sc; sw_wdata = 8'($urandom);
      for (int n = 1; n <= 60; n++) begin
        @(negedge clk);
        sw_start = 1'b0;
        sw_cmd = 2'($urandom);
        for (int g = 0; g < 4; g++) begin
          if (sw_lat[g] == 0) begin
            if (sw_ss_n[g] === 1'b1 && sw_busy[g] === 1'b1) sw_gap[g]++;
            if (sw_done[g] === 1'b1) sw_lat[g] = n;
          end
        end
      end
      for (int g = 0; g < 4; g++) begin
        check($sformatf("sweep_lat_cmd%0d_t%0d_g%0d", sc, SW_T[g], SW_G[g]),
              sw_lat[g], exp_latency(sc, SW_T[g], SW_G[g]));
        check($sformatf("sweep_gap_cmd%0d_t%0d_g%0d", sc, SW_T[g], SW_G[g]),
              sw_gap[g], SW_G[g]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
